// File: rtl/rr_arb_pkg.sv
// Shared types, sizes and helpers for the four-way round-robin arbiter.
package rr_arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  // Arbiter phases: waiting for a request, serving an owner, post-release gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Number of bits needed to count value distinct states (0 for value <= 1).
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first eligible requester after 'last', wrapping.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] elig,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] sel,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // Scan last+1, last+2, ... last+4 (modulo 4); the first eligible index wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = last + IDX_W'(k);
      if (!any && elig[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with one-hot and encoded grant, hold
// timeout, post-release gap and per-requester lockout after a forced release.
// The FSM state is kept in the 'state' signal for hierarchical observation.
module rr_arb4_enc
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             e1,
  output logic             e0,
  output logic             gnt_valid,
  output logic             timeout,
  output logic [N_REQ-1:0] lockout
);

  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam int GAP_W  = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last, last_nxt;     // last granted index; equals the owner while BUSY
  logic [HOLD_W-1:0] hold, hold_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [N_REQ-1:0]  gnt_nxt, lock_nxt;
  logic [IDX_W-1:0]  idx_q, idx_nxt;
  logic              valid_nxt, to_nxt;
  logic [N_REQ-1:0]  elig;
  logic [IDX_W-1:0]  sel;
  logic              any;
  logic              release_now, forced;

  assign elig = req & ~lockout;
  assign e1   = idx_q[1];
  assign e0   = idx_q[0];

  rr_pick4 u_pick (
    .elig (elig),
    .last (last),
    .sel  (sel),
    .any  (any)
  );

  // Next-state, counter, lockout and registered-output computation.
  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    hold_nxt    = hold;
    gap_nxt     = gap_cnt;
    gnt_nxt     = '0;
    idx_nxt     = '0;
    valid_nxt   = 1'b0;
    to_nxt      = 1'b0;
    // A requester that drops its request is forgiven; a new lockout below overrides.
    lock_nxt    = lockout & req;
    release_now = 1'b0;
    forced      = 1'b0;
    case (state)
      IDLE: begin
        if (any) begin
          state_nxt = BUSY;
          gnt_nxt   = N_REQ'(1) << sel;
          idx_nxt   = sel;
          valid_nxt = 1'b1;
          hold_nxt  = HOLD_W'(1);
          last_nxt  = sel;
        end
      end
      BUSY: begin
        release_now = !req[last];
        forced      = req[last] && (hold == HOLD_W'(MAX_HOLD));
        if (release_now || forced) begin
          hold_nxt  = '0;
          gap_nxt   = '0;
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
          if (forced) begin
            to_nxt         = 1'b1;
            lock_nxt[last] = 1'b1;
          end
        end else begin
          gnt_nxt   = gnt;
          idx_nxt   = idx_q;
          valid_nxt = 1'b1;
          if (hold != HOLD_W'(MAX_HOLD)) hold_nxt = hold + HOLD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          gap_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and output registers; reset restarts the search at requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IDX_W'(N_REQ - 1);
      hold      <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      idx_q     <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      lockout   <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      hold      <= hold_nxt;
      gap_cnt   <= gap_nxt;
      gnt       <= gnt_nxt;
      idx_q     <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= to_nxt;
      lockout   <= lock_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Bench for rr_arb4_enc: three configurations share clk/rst/req.
//   a: MAX_HOLD=16 GAP=1, b: MAX_HOLD=4 GAP=1, c: MAX_HOLD=1 GAP=0.
module tb_rr_arb4_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] a_gnt, b_gnt, c_gnt, a_lock, b_lock, c_lock;
  logic       a_e1, a_e0, a_valid, a_to;
  logic       b_e1, b_e0, b_valid, b_to;
  logic       c_e1, c_e0, c_valid, c_to;
  logic [11:0] a_obs, b_obs, c_obs;

  int checks = 0;
  int errors = 0;

  // clock
  always #5 clk = ~clk;

  rr_arb4_enc #(.MAX_HOLD(16), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req(req), .gnt(a_gnt), .e1(a_e1), .e0(a_e0),
    .gnt_valid(a_valid), .timeout(a_to), .lockout(a_lock));
  rr_arb4_enc #(.MAX_HOLD(4), .GAP_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .req(req), .gnt(b_gnt), .e1(b_e1), .e0(b_e0),
    .gnt_valid(b_valid), .timeout(b_to), .lockout(b_lock));
  rr_arb4_enc #(.MAX_HOLD(1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .req(req), .gnt(c_gnt), .e1(c_e1), .e0(c_e0),
    .gnt_valid(c_valid), .timeout(c_to), .lockout(c_lock));

  // observation vector: {gnt, e1, e0, gnt_valid, timeout, lockout}
  assign a_obs = {a_gnt, a_e1, a_e0, a_valid, a_to, a_lock};
  assign b_obs = {b_gnt, b_e1, b_e0, b_valid, b_to, b_lock};
  assign c_obs = {c_gnt, c_e1, c_e0, c_valid, c_to, c_lock};

  // ---------------- reference model (one copy per configuration) ----------------
  int         mh[3] = '{16, 4, 1};
  int         gp[3] = '{1, 1, 0};
  int         m_own[3];   // owner index, -1 when nobody owns
  int         m_hold[3];
  int         m_gap[3];   // remaining gap cycles
  int         m_last[3];
  logic [3:0] m_lock[3];
  logic       m_to[3];

  task automatic model_step(input int j);
    logic [3:0] nl;
    bit found;
    int c;
    nl = m_lock[j] & req;
    m_to[j] = 1'b0;
    found = 1'b0;
    if (m_own[j] >= 0) begin
      if (!req[m_own[j]] || m_hold[j] == mh[j]) begin
        if (req[m_own[j]]) begin
          m_to[j] = 1'b1;
          nl[m_own[j]] = 1'b1;
        end
        m_own[j] = -1;
        m_gap[j] = gp[j];
      end else begin
        m_hold[j] = m_hold[j] + 1;
      end
    end else if (m_gap[j] > 0) begin
      m_gap[j] = m_gap[j] - 1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_last[j] + k) % 4;
        if (!found && req[c] && !m_lock[j][c]) begin
          found     = 1'b1;
          m_own[j]  = c;
          m_hold[j] = 1;
          m_last[j] = c;
        end
      end
    end
    m_lock[j] = nl;
  endtask

  function automatic logic [11:0] exp_obs(input int j);
    logic [3:0] g;
    logic [1:0] e;
    g = (m_own[j] >= 0) ? (4'b0001 << m_own[j]) : 4'b0000;
    e = (m_own[j] >= 0) ? 2'(m_own[j]) : 2'b00;
    return {g, e, (m_own[j] >= 0), m_to[j], m_lock[j]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 3; j++) begin
        m_own[j] = -1; m_hold[j] = 0; m_gap[j] = 0; m_last[j] = 3;
        m_lock[j] = 4'b0000; m_to[j] = 1'b0;
      end
    end else begin
      for (int j = 0; j < 3; j++) model_step(j);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req = 4'b1111;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_obs, b_obs, c_obs} !== 36'h0) begin
      errors++;
      $display("FAIL reset_async got a=%h b=%h c=%h exp 000", a_obs, b_obs, c_obs);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a_obs !== {4'b0001, 2'b00, 1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL reset_first_grant got %h exp %h", a_obs, {4'b0001, 2'b00, 1'b1, 1'b0, 4'b0000});
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({a_gnt, a_e1, a_e0, a_valid} !== 7'b0100_10_1) begin
        errors++;
        $display("FAIL single_hold_%0d got %b exp 0100101", i, {a_gnt, a_e1, a_e0, a_valid});
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (a_obs !== 12'h000) begin
      errors++;
      $display("FAIL single_release got %h exp 000", a_obs);
    end
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (a_obs !== 12'h000) begin
      errors++;
      $display("FAIL single_gap got %h exp 000", a_obs);
    end
    @(negedge clk);
    checks++;
    if ({a_gnt, a_e1, a_e0, a_valid} !== 7'b0100_10_1) begin
      errors++;
      $display("FAIL single_regrant got %b exp 0100101", {a_gnt, a_e1, a_e0, a_valid});
    end
  endtask

  task automatic test_rotation();
    int n;
    int exp_i;
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_i = k % 4;
      exp_g = 4'b0001 << exp_i;
      n = 0;
      while (!a_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if ({a_gnt, a_e1, a_e0, a_valid} !== {exp_g, 2'(exp_i), 1'b1}) begin
        errors++;
        $display("FAIL rotation_%0d got %b exp %b", k, {a_gnt, a_e1, a_e0, a_valid}, {exp_g, 2'(exp_i), 1'b1});
      end
      @(negedge clk);
      checks++;
      if (a_gnt !== exp_g) begin
        errors++;
        $display("FAIL rotation_hold_%0d got %b exp %b", k, a_gnt, exp_g);
      end
      req[exp_i] = 1'b0;
      @(negedge clk);
      req[exp_i] = 1'b1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 4'b0010;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({b_gnt, b_e1, b_e0, b_valid} !== 7'b0010_01_1) begin
        errors++;
        $display("FAIL timeout_hold_%0d got %b exp 0010011", i, {b_gnt, b_e1, b_e0, b_valid});
      end
      if (i == 1) begin
        checks++;
        if ({c_gnt, c_valid} !== 5'b0010_1) begin
          errors++;
          $display("FAIL maxhold1_grant got %b exp 00101", {c_gnt, c_valid});
        end
      end
      if (i == 2) begin
        checks++;
        if (c_obs !== {4'b0000, 2'b00, 1'b0, 1'b1, 4'b0010}) begin
          errors++;
          $display("FAIL maxhold1_release got %h exp %h", c_obs, {4'b0000, 2'b00, 1'b0, 1'b1, 4'b0010});
        end
      end
    end
    @(negedge clk);
    checks++;
    if (b_obs !== {4'b0000, 2'b00, 1'b0, 1'b1, 4'b0010}) begin
      errors++;
      $display("FAIL timeout_pulse got %h exp %h", b_obs, {4'b0000, 2'b00, 1'b0, 1'b1, 4'b0010});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (b_obs !== {4'b0000, 2'b00, 1'b0, 1'b0, 4'b0010}) begin
        errors++;
        $display("FAIL timeout_locked_%0d got %h exp %h", i, b_obs, {4'b0000, 2'b00, 1'b0, 1'b0, 4'b0010});
      end
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (b_obs !== 12'h000) begin
      errors++;
      $display("FAIL timeout_unlock got %h exp 000", b_obs);
    end
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if ({b_gnt, b_valid, b_lock} !== 9'b0010_1_0000) begin
      errors++;
      $display("FAIL timeout_regrant got %b exp 001010000", {b_gnt, b_valid, b_lock});
    end
  endtask

  task automatic test_lockout_others();
    do_reset();
    req = 4'b1001;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if ({b_gnt, b_e1, b_e0, b_valid} !== 7'b0001_00_1) begin
        errors++;
        $display("FAIL lockout_hold_%0d got %b exp 0001001", i, {b_gnt, b_e1, b_e0, b_valid});
      end
    end
    @(negedge clk);
    checks++;
    if (b_obs !== {4'b0000, 2'b00, 1'b0, 1'b1, 4'b0001}) begin
      errors++;
      $display("FAIL lockout_timeout got %h exp %h", b_obs, {4'b0000, 2'b00, 1'b0, 1'b1, 4'b0001});
    end
    @(negedge clk);
    checks++;
    if (b_obs !== {4'b0000, 2'b00, 1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL lockout_gap got %h exp %h", b_obs, {4'b0000, 2'b00, 1'b0, 1'b0, 4'b0001});
    end
    @(negedge clk);
    checks++;
    if (b_obs !== {4'b1000, 2'b11, 1'b1, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL lockout_other_grant got %h exp %h", b_obs, {4'b1000, 2'b11, 1'b1, 1'b0, 4'b0001});
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({a_gnt, a_e1, a_e0, a_valid} !== 7'b0100_10_1) begin
        errors++;
        $display("FAIL no_preempt_%0d got %b exp 0100101", i, {a_gnt, a_e1, a_e0, a_valid});
      end
    end
    req = 4'b0011;
    repeat (2) @(negedge clk);
    checks++;
    if (a_obs !== 12'h000) begin
      errors++;
      $display("FAIL no_preempt_gap got %h exp 000", a_obs);
    end
    @(negedge clk);
    checks++;
    if ({a_gnt, a_e1, a_e0, a_valid} !== 7'b0001_00_1) begin
      errors++;
      $display("FAIL no_preempt_next got %b exp 0001001", {a_gnt, a_e1, a_e0, a_valid});
    end
  endtask

  task automatic test_random();
    logic [11:0] obs;
    logic [11:0] exp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        obs = (j == 0) ? a_obs : (j == 1) ? b_obs : c_obs;
        exp = exp_obs(j);
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random_cfg%0d_cyc%0d got %h exp %h req %b", j, n, obs, exp, req);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_timeout();
    test_lockout_others();
    test_no_preempt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
